multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback for one instruction at a time. Drives the datapath mux selects and write enables, and drives the 4-bit `ALUop` consumed by the ALU control decoder: `1111` means "decode FuncCode"; any other value is passed through as the ALU control code. Stalls on a single-port memory via a ready handshake.

## Interface
Parameters: none.
- `CLK` in 1: clock, rising edge.
- `Reset_L` in 1: asynchronous, active-low reset.
- `Opcode` in 6: IR[31:26]; stable from DECODE through end of instruction.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1: datapath controls.
- `ALUSrcB` out 2: 00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `ALUop` out 4: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, R-type 1111.
- `State` out 4: current state encoding, for debug.
- `InstrDone` out 1: one-cycle pulse in the final cycle of each instruction.
- `Illegal` out 1: one-cycle pulse in DECODE on an unsupported opcode.

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11
- 12–15 are unused and go to FETCH on the next edge.

Per-state behaviour (outputs not listed are 0):
- **FETCH**: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=ADD, PCSource=00.
  - IRWrite and PCWrite are asserted only when MemReady=1.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- **DECODE**: ALUSrcA=0, ALUSrcB=11, ALUop=ADD (branch target into ALUOut). Next state by Opcode:
  - 000000 → REXEC
  - 100011 (lw), 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000, 001100, 001101, 001010 (addi/andi/ori/slti) → IEXEC
  - any other opcode → FETCH, with Illegal=1 and InstrDone=1
- **MEMADR**: ALUSrcA=1, ALUSrcB=10, ALUop=ADD. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD**: MemRead=1, IorD=1. Waits on MemReady, then goes to MEMWB.
- **MEMWB**: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1. Goes to FETCH.
- **MEMWR**: MemWrite=1, IorD=1. Waits on MemReady. InstrDone=MemReady. Goes to FETCH when MemReady=1.
- **REXEC**: ALUSrcA=1, ALUSrcB=00, ALUop=1111. Goes to RWB.
- **RWB**: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1. Goes to FETCH.
- **BRANCH**: ALUSrcA=1, ALUSrcB=00, ALUop=SUB, PCWriteCond=1, PCSource=01, InstrDone=1. Goes to FETCH.
- **JUMP**: PCWrite=1, PCSource=10, InstrDone=1. Goes to FETCH.
- **IEXEC**: ALUSrcA=1, ALUSrcB=10. ALUop is ADD for addi, AND for andi, OR for ori, SLT for slti. Goes to IWB.
- **IWB**: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1. Goes to FETCH.
- **Unused states (12–15)**: all outputs 0.

## Timing
- Reset:
  - Asserting Reset_L low forces State=FETCH immediately, without waiting for a clock edge.
  - While Reset_L=0, every enable is 0: PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, InstrDone, Illegal.
  - The mux selects take their FETCH values during reset.
  - Reset in the middle of an instruction abandons it; no write enable may glitch high.
- Outputs are Moore decodes of State. The only exceptions are FETCH IRWrite/PCWrite and MEMWR InstrDone, which are also gated by MemReady.
- Minimum cycle counts with MemReady tied high:
  - beq, j: 3
  - R-type, I-type, sw: 4
  - lw: 5
- Each cycle MemReady is low adds exactly one cycle in FETCH, MEMRD or MEMWR.
- MemReady is ignored in every other state.
- MemRead and MemWrite are never asserted in the same cycle.

## Structure
- Shared package holds:
  - state encodings
  - opcode constants (R, LW, SW, BEQ, J, ADDI, ANDI, ORI, SLTI)
  - ALUop constants, which the ALU control decoder also uses
- One sub-module, `imm_aluop_decode`: combinational map from Opcode to ALUop for IEXEC.
- Controller body: a state register plus a next-state/output case.

## Test plan
- **Reset mid-MEMRD**: hold MemReady=0 in MEMRD, pull Reset_L low → State=0 asynchronously, all enables 0. After release, FETCH resumes.
- **R-type, MemReady=1**: Opcode=000000 → states 0,1,6,7. ALUop=1111 in REXEC. RegDst=1 and RegWrite=1 in RWB. InstrDone pulses in cycle 4.
- **lw with two wait cycles at each memory access**: Opcode=100011 → FETCH ×3, DECODE, MEMADR, MEMRD ×3, MEMWB (9 cycles). MemtoReg=1 in the last cycle. IRWrite asserts only once.
- **andi**: Opcode=001100 → ALUop=0000 and ALUSrcB=10 in IEXEC. IWB has RegDst=0, RegWrite=1.
- **beq then j**: Opcode=000100 → BRANCH with ALUop=0110, PCWriteCond=1, PCSource=01. Opcode=000010 → JUMP with PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- **Illegal opcode**: Opcode=111111 → Illegal and InstrDone pulse together in DECODE, next state=FETCH, no write enable asserted.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multi-cycle MIPS main controller:
//   - state_t     : controller state encodings (also exported on the State port)
//   - OP_*        : instruction opcode constants (IR[31:26])
//   - ALU_*       : ALUop codes, shared with the ALU control decoder
//   - decode_next : DECODE-state dispatch from opcode to the first execute state
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_RTYPE = 4'b1111;

  // Unsupported opcodes dispatch back to FETCH; the controller uses that
  // return value to recognise an illegal instruction.
  function automatic state_t decode_next(input logic [5:0] opcode);
    state_t ns;
    case (opcode)
      OP_R:                            ns = S_REXEC;
      OP_LW, OP_SW:                    ns = S_MEMADR;
      OP_BEQ:                          ns = S_BRANCH;
      OP_J:                            ns = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: ns = S_IEXEC;
      default:                         ns = S_FETCH;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/multicycle_control_imm_aluop_decode.sv
// -----------------------------------------------------------------------------
// imm_aluop_decode
// Combinational map from an I-type opcode to the ALU operation used in IEXEC.
//   i_opcode : IR[31:26]
//   o_aluop  : ALU control code (ADD for anything that is not andi/ori/slti)
// -----------------------------------------------------------------------------
module imm_aluop_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [3:0] o_aluop
);

  // Opcode to ALU operation lookup
  always_comb begin
    o_aluop = ALU_ADD;
    case (i_opcode)
      OP_ADDI: o_aluop = ALU_ADD;
      OP_ANDI: o_aluop = ALU_AND;
      OP_ORI:  o_aluop = ALU_OR;
      OP_SLTI: o_aluop = ALU_SLT;
      default: o_aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multi-cycle MIPS datapath. One instruction at a time
// is sequenced through fetch/decode/execute/memory/writeback; memory states
// stall on MemReady.
//   CLK, Reset_L      : clock (rising edge), async active-low reset
//   Opcode, MemReady  : IR[31:26] and memory-access-complete handshake
//   PCWrite..ALUSrcA  : datapath write enables and 1-bit mux selects
//   ALUSrcB, PCSource : 2-bit mux selects
//   ALUop             : ALU control code (1111 = decode FuncCode)
//   State             : current state (debug)
//   InstrDone/Illegal : final-cycle pulse / unsupported-opcode pulse in DECODE
// -----------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUop,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_imm_aluop;

  // Raw (ungated) enables produced by the state decode
  logic w_pcwrite, w_pcwritecond, w_memread, w_memwrite, w_irwrite;
  logic w_regwrite, w_instrdone, w_illegal;

  imm_aluop_decode u_imm_aluop_decode (
    .i_opcode (Opcode),
    .o_aluop  (w_imm_aluop)
  );

  // State register; reset forces FETCH without waiting for a clock edge
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode of the current state
  always_comb begin
    w_next        = S_FETCH;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_regwrite    = 1'b0;
    w_instrdone   = 1'b0;
    w_illegal     = 1'b0;
    IorD          = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALUop         = 4'b0000;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        ALUSrcB   = 2'b01;
        ALUop     = ALU_ADD;
        // IR and PC+4 are captured only in the cycle the read completes
        w_irwrite = MemReady;
        w_pcwrite = MemReady;
        w_next    = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUop   = ALU_ADD;
        w_next  = decode_next(Opcode);
        if (decode_next(Opcode) == S_FETCH) begin
          w_illegal   = 1'b1;
          w_instrdone = 1'b1;
        end else begin
          w_illegal   = 1'b0;
          w_instrdone = 1'b0;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = ALU_ADD;
        w_next  = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        IorD      = 1'b1;
        w_next    = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_memwrite  = 1'b1;
        IorD        = 1'b1;
        w_instrdone = MemReady;
        w_next      = MemReady ? S_FETCH : S_MEMWR;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_RTYPE;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegDst      = 1'b1;
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUop         = ALU_SUB;
        w_pcwritecond = 1'b1;
        PCSource      = 2'b01;
        w_instrdone   = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        w_pcwrite   = 1'b1;
        PCSource    = 2'b10;
        w_instrdone = 1'b1;
        w_next      = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = w_imm_aluop;
        w_next  = S_IWB;
      end
      S_IWB: begin
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
        w_next      = S_FETCH;
      end
      default: begin
        // Encodings 12-15: everything low, recover to FETCH
        w_next = S_FETCH;
      end
    endcase
  end

  // Enables are forced low while reset is held even though the state already
  // reads FETCH, so nothing is written during or on entry to reset.
  assign PCWrite     = w_pcwrite     & Reset_L;
  assign PCWriteCond = w_pcwritecond & Reset_L;
  assign MemRead     = w_memread     & Reset_L;
  assign MemWrite    = w_memwrite    & Reset_L;
  assign IRWrite     = w_irwrite     & Reset_L;
  assign RegWrite    = w_regwrite    & Reset_L;
  assign InstrDone   = w_instrdone   & Reset_L;
  assign Illegal     = w_illegal     & Reset_L;
  assign State       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Each instruction is expanded into the list of (state, MemReady) cycles it
// must occupy; the expected output word for every cycle comes from the
// per-state output table. A negedge compare process checks the DUT each cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       Reset_L;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, InstrDone, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUop, State;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcsrc;
    logic [3:0] aluop, st;
    logic       done, ill;
  } outs_t;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  outs_t act_o, exp_o;
  logic  chk_en;
  int    n_vec = 0;
  int    n_err = 0;

  multicycle_control dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .State(State), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  assign act_o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                  ALUop, State, InstrDone, Illegal};

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101, 6'b001010};
  endfunction

  // Output table per state, straight from the state descriptions
  function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic mr);
    outs_t o;
    o = '0;
    o.st = 4'(st);
    case (st)
      0:  begin o.mrd = 1'b1; o.srcb = 2'b01; o.aluop = 4'b0010; o.irw = mr; o.pcw = mr; end
      1:  begin o.srcb = 2'b11; o.aluop = 4'b0010;
                if (!legal(op)) begin o.ill = 1'b1; o.done = 1'b1; end end
      2:  begin o.srca = 1'b1; o.srcb = 2'b10; o.aluop = 4'b0010; end
      3:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      4:  begin o.m2r = 1'b1; o.rw = 1'b1; o.done = 1'b1; end
      5:  begin o.mwr = 1'b1; o.iord = 1'b1; o.done = mr; end
      6:  begin o.srca = 1'b1; o.aluop = 4'b1111; end
      7:  begin o.rdst = 1'b1; o.rw = 1'b1; o.done = 1'b1; end
      8:  begin o.srca = 1'b1; o.aluop = 4'b0110; o.pcwc = 1'b1; o.pcsrc = 2'b01; o.done = 1'b1; end
      9:  begin o.pcw = 1'b1; o.pcsrc = 2'b10; o.done = 1'b1; end
      10: begin o.srca = 1'b1; o.srcb = 2'b10;
                o.aluop = (op == 6'b001100) ? 4'b0000 :
                          (op == 6'b001101) ? 4'b0001 :
                          (op == 6'b001010) ? 4'b0111 : 4'b0010; end
      11: begin o.rw = 1'b1; o.done = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      n_vec++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL outputs t=%0t exp_state=%0d: got %h, expected %h",
                 $time, exp_o.st, act_o, exp_o);
      end
    end
  end

  // Build the cycle sequence of one instruction and drive it
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           output int n_steps, output int n_cyc, output int n_irw);
    step_t q[$];
    step_t s;
    for (int i = 0; i < wf; i++) begin s.st = 0; s.mr = 1'b0; q.push_back(s); end
    s.st = 0; s.mr = 1'b1; q.push_back(s);
    s.st = 1; s.mr = 1'($urandom); q.push_back(s);
    if (op == 6'b000000) begin
      s.st = 6; s.mr = 1'($urandom); q.push_back(s);
      s.st = 7; s.mr = 1'($urandom); q.push_back(s);
    end else if (op == 6'b100011) begin
      s.st = 2; s.mr = 1'($urandom); q.push_back(s);
      for (int i = 0; i < wm; i++) begin s.st = 3; s.mr = 1'b0; q.push_back(s); end
      s.st = 3; s.mr = 1'b1; q.push_back(s);
      s.st = 4; s.mr = 1'($urandom); q.push_back(s);
    end else if (op == 6'b101011) begin
      s.st = 2; s.mr = 1'($urandom); q.push_back(s);
      for (int i = 0; i < wm; i++) begin s.st = 5; s.mr = 1'b0; q.push_back(s); end
      s.st = 5; s.mr = 1'b1; q.push_back(s);
    end else if (op == 6'b000100) begin
      s.st = 8; s.mr = 1'($urandom); q.push_back(s);
    end else if (op == 6'b000010) begin
      s.st = 9; s.mr = 1'($urandom); q.push_back(s);
    end else if (legal(op)) begin
      s.st = 10; s.mr = 1'($urandom); q.push_back(s);
      s.st = 11; s.mr = 1'($urandom); q.push_back(s);
    end
    n_steps = q.size();
    n_cyc = 0;
    n_irw = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge CLK);
      #1;
      // Opcode only has to be valid from DECODE onward
      Opcode   = (q[i].st == 0) ? 6'($urandom) : op;
      MemReady = q[i].mr;
      exp_o    = exp_out(q[i].st, op, q[i].mr);
      chk_en   = 1'b1;
      @(negedge CLK);
      n_irw += int'(IRWrite);
      if (InstrDone && n_cyc == 0) n_cyc = i + 1;
    end
  endtask

  logic [5:0] ops [9];
  int ns, nc, ni;

  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
            6'b001000, 6'b001100, 6'b001101, 6'b001010};
    chk_en = 1'b0; exp_o = '0;
    Reset_L = 1'b0; MemReady = 1'b0; Opcode = 6'b000000;
    #3;
    chk("reset_state", int'(State), 0);
    chk("reset_enables", int'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite,
                               RegWrite, InstrDone, Illegal}), 0);
    chk("reset_alusrcb", int'(ALUSrcB), 1);
    @(negedge CLK); @(negedge CLK);
    Reset_L = 1'b1;

    // Reset in the middle of a stalled lw read
    Opcode = 6'b100011; MemReady = 1'b1;
    repeat (3) @(posedge CLK);
    #1 MemReady = 1'b0;
    @(posedge CLK); #2;
    chk("memrd_stall_state", int'(State), 3);
    chk("memrd_stall_memread", int'(MemRead), 1);
    Reset_L = 1'b0;
    #1;
    chk("async_reset_state", int'(State), 0);
    chk("async_reset_enables", int'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite,
                                     RegWrite, InstrDone, Illegal}), 0);
    @(posedge CLK); #1;
    chk("held_reset_memread", int'(MemRead), 0);
    @(negedge CLK);
    Reset_L = 1'b1;
    #1;
    chk("release_fetch_memread", int'(MemRead), 1);

    // Directed instructions with literal cycle counts
    run_instr(6'b000000, 0, 0, ns, nc, ni);
    chk("rtype_model_len", ns, 4);  chk("rtype_done_cycle", nc, 4);
    run_instr(6'b100011, 2, 2, ns, nc, ni);
    chk("lw_model_len", ns, 9);     chk("lw_done_cycle", nc, 9);
    chk("lw_irwrite_once", ni, 1);
    run_instr(6'b101011, 0, 0, ns, nc, ni);
    chk("sw_done_cycle", nc, 4);
    run_instr(6'b001100, 0, 0, ns, nc, ni);
    chk("andi_done_cycle", nc, 4);
    run_instr(6'b000100, 0, 0, ns, nc, ni);
    chk("beq_model_len", ns, 3);    chk("beq_done_cycle", nc, 3);
    run_instr(6'b000010, 0, 0, ns, nc, ni);
    chk("j_done_cycle", nc, 3);
    run_instr(6'b111111, 0, 0, ns, nc, ni);
    chk("illegal_model_len", ns, 2); chk("illegal_done_cycle", nc, 2);
    run_instr(6'b100011, 0, 0, ns, nc, ni);
    chk("lw_min_cycles", nc, 5);

    // Randomized instruction stream with random memory wait states
    for (int k = 0; k < 200; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 8)];
      else op = 6'($urandom);
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ns, nc, ni);
      chk("rand_done_cycle", nc, ns);
      chk("rand_irwrite_once", ni, 1);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
